// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register index/word widths, named
// architectural register indices and the matching typedefs.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [WORD_W-1:0]     word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file: index decode, $zero forcing
// and, when REGFILE_BYPASS_EN is defined, same-cycle write-to-read forwarding.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                                     rst_n,
    input  logic [ADDR_WIDTH-1:0]                    read_reg,
    input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
`ifdef REGFILE_BYPASS_EN
    input  logic                                     reg_write,
    input  logic [ADDR_WIDTH-1:0]                    write_reg,
    input  logic [DATA_WIDTH-1:0]                    write_data,
`endif
    output logic [DATA_WIDTH-1:0]                    read_data
);

    logic                  zero_hit_s;
    logic                  bypass_hit_s;
    logic [DATA_WIDTH-1:0] bypass_data_s;

    assign zero_hit_s = (read_reg == ADDR_WIDTH'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write; a $zero target never forwards.
    assign bypass_hit_s  = reg_write && (write_reg == read_reg) && !zero_hit_s;
    assign bypass_data_s = write_data;
`else
    assign bypass_hit_s  = 1'b0;
    assign bypass_data_s = '0;
`endif

    // Output select: reset and $zero dominate, then forwarding, then storage.
    always_comb begin
        read_data = '0;
        if (!rst_n) begin
            read_data = '0;
        end else if (zero_hit_s) begin
            read_data = '0;
        end else if (bypass_hit_s) begin
            read_data = bypass_data_s;
        end else begin
            read_data = regs[read_reg];
        end
    end

endmodule

// File: rtl/reg_file.sv
// MIPS architectural register file: 2**ADDR_WIDTH words, two combinational
// read ports, one clocked write port. Optional feature macro: REGFILE_BYPASS_EN.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    // Index 0 has no storage at all, so a write there cannot land anywhere.
    logic [DATA_WIDTH-1:0]            regs_r [1:DEPTH-1];
    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_flat_s;

    // Storage update: async clear, otherwise enabled write to a nonzero index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (reg_write && (write_reg == ADDR_WIDTH'(i))) begin
                    regs_r[i] <= write_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Flatten storage for the read ports, with a constant zero in slot 0.
    always_comb begin
        regs_flat_s[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            regs_flat_s[i] = regs_r[i];
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port1 (
        .rst_n      (rst_n),
        .read_reg   (read_reg1),
        .regs       (regs_flat_s),
`ifdef REGFILE_BYPASS_EN
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
`endif
        .read_data  (read_data1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port2 (
        .rst_n      (rst_n),
        .read_reg   (read_reg2),
        .regs       (regs_flat_s),
`ifdef REGFILE_BYPASS_EN
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
`endif
        .read_data  (read_data2)
    );

endmodule
